shift_arbiter_ctrl: RTL

Two-requester scheduler that shares the 5-stage, 8-bit delay line (`shift_register`) between independent byte sources. Arbitrates one byte per cycle into stage 0 and inserts 8'h00 bubbles on idle cycles. Carries a valid bit and a requester-ID bit alongside each byte, so every output byte is tagged with its origin. Provides a flush/drain sequence that stops admission and reports when the line is empty.

---
 rtl/shift_arbiter_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/shift_arbiter_ctrl.sv
// shift_arbiter_ctrl: two-requester scheduler feeding a 5-stage byte delay line.
// One byte per cycle is arbitrated into stage 0. Idle cycles insert 8'h00 bubbles.
// Valid and requester-ID shadow chains tag each output byte with its origin.
// A flush/drain sequence stops admission and pulses flush_done once the line is empty.
// Optional macro SHIFT_ARB_FIXED_PRIO_EN: req0 always beats req1, and no last_id register is built.

module shift_register #(
  parameter int unsigned DEPTH = 5,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q;
  logic [DEPTH-1:0][WIDTH-1:0] stage_d;

  // shift one stage per cycle; stage 0 takes din
  always_comb begin
    stage_d = {stage_q[DEPTH-2:0], din};
  end

  // stage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

module shift_arbiter_ctrl #(
  parameter int unsigned DEPTH = 5,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] din0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] din1,
  output logic             gnt1,
  input  logic             flush,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             dout_id,
  output logic [2:0]       occupancy,
  output logic             busy,
  output logic             flush_done
);

  localparam int unsigned OCC_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [DEPTH-1:0]   id_q, id_d;
  logic               xfer;
  logic               xfer_id;
  logic [WIDTH-1:0]   xfer_data;

`ifndef SHIFT_ARB_FIXED_PRIO_EN
  logic               last_id_q, last_id_d;
`endif

  // grant selection; admission is closed during reset, flush and drain
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && !flush && (state_q != ST_DRAIN)) begin
`ifdef SHIFT_ARB_FIXED_PRIO_EN
      gnt0 = req0;
      gnt1 = req1 & ~req0;
`else
      if (req0 && req1) begin
        gnt0 = last_id_q;
        gnt1 = ~last_id_q;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
`endif
    end
  end

  // transfer decode and stage-0 byte (bubble when nothing is granted)
  always_comb begin
    xfer      = (req0 & gnt0) | (req1 & gnt1);
    xfer_id   = req1 & gnt1;
    xfer_data = '0;
    if (req1 && gnt1) begin
      xfer_data = din1;
    end else if (req0 && gnt0) begin
      xfer_data = din0;
    end
  end

  shift_register #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_line (
    .clk  (clk),
    .rst  (rst),
    .din  (xfer_data),
    .dout (dout)
  );

  assign dout_valid = valid_q[DEPTH-1];
  assign dout_id    = id_q[DEPTH-1];
  assign occupancy  = occ_q;
  assign busy       = (state_q != ST_IDLE);

  // shadow chains, occupancy count and round-robin pointer next values
  always_comb begin
    valid_d = {valid_q[DEPTH-2:0], xfer};
    id_d    = {id_q[DEPTH-2:0], xfer_id};
    occ_d   = occ_q + OCC_W'(xfer) - OCC_W'(dout_valid);
`ifndef SHIFT_ARB_FIXED_PRIO_EN
    last_id_d = xfer ? xfer_id : last_id_q;
`endif
  end

  // control FSM: flush has top priority except while already draining
  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          state_d = ST_DRAIN;
        end else if (xfer) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_d = ST_DRAIN;
        end else if (occ_d == '0) begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (occ_q == '0) begin
          state_d    = ST_IDLE;
          flush_done = ~rst;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state, shadow and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      occ_q   <= '0;
      valid_q <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      valid_q <= valid_d;
      id_q    <= id_d;
    end
  end

`ifndef SHIFT_ARB_FIXED_PRIO_EN
  // round-robin pointer; reset to 1 so req0 wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      last_id_q <= 1'b1;
    end else begin
      last_id_q <= last_id_d;
    end
  end
`endif

endmodule
